ipg_slot_sched: RTL and testbench

- Scheduler that shares the idle-block injection slots of the 64b/66b TX stream between several IPG message requesters.
- Watches each next encoded block from the MAC/encoder and grants one requester at a time, round-robin.
- Issues a chunk pop strobe only for blocks that are pure idle and follow a minimum post-frame gap.
- Drives the registered ipg_en select for the downstream TX block mux that substitutes IPG chunks for idle blocks.

---
 rtl/ipg_pkg.sv | 48 ++++
 rtl/ipg_rr_arb.sv | 27 ++
 rtl/ipg_slot_sched.sv | 159 +++++++++++++++
 tb/tb_ipg_slot_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG slot scheduler: 64b/66b sync headers,
// block type codes, idle/terminate block classifiers and the FSM state type.
package ipg_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] BLOCK_TYPE_CTRL     = 8'h1e;
    localparam logic [7:0] BLOCK_TYPE_START_0  = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_START_4  = 8'h33;
    localparam logic [7:0] BLOCK_TYPE_OS_0     = 8'h4b;
    localparam logic [7:0] BLOCK_TYPE_OS_4     = 8'h2d;
    localparam logic [7:0] BLOCK_TYPE_OS_START = 8'h66;
    localparam logic [7:0] BLOCK_TYPE_OS_OS    = 8'h55;
    localparam logic [7:0] BLOCK_TYPE_TERM_0   = 8'h87;
    localparam logic [7:0] BLOCK_TYPE_TERM_1   = 8'h99;
    localparam logic [7:0] BLOCK_TYPE_TERM_2   = 8'haa;
    localparam logic [7:0] BLOCK_TYPE_TERM_3   = 8'hb4;
    localparam logic [7:0] BLOCK_TYPE_TERM_4   = 8'hcc;
    localparam logic [7:0] BLOCK_TYPE_TERM_5   = 8'hd2;
    localparam logic [7:0] BLOCK_TYPE_TERM_6   = 8'he1;
    localparam logic [7:0] BLOCK_TYPE_TERM_7   = 8'hff;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // A pure idle block: control header, type 0x1e and all eight idle codes zero.
    function automatic logic is_idle_blk(input logic [1:0] hdr, input logic [63:0] data);
        return (hdr == SYNC_CTRL) && (data[7:0] == BLOCK_TYPE_CTRL) && (data[63:8] == 56'd0);
    endfunction

    // Any of the eight terminate block types under a control header.
    function automatic logic is_term_blk(input logic [1:0] hdr, input logic [63:0] data);
        logic term_v;
        case (data[7:0])
            BLOCK_TYPE_TERM_0, BLOCK_TYPE_TERM_1, BLOCK_TYPE_TERM_2, BLOCK_TYPE_TERM_3,
            BLOCK_TYPE_TERM_4, BLOCK_TYPE_TERM_5, BLOCK_TYPE_TERM_6, BLOCK_TYPE_TERM_7:
                term_v = (hdr == SYNC_CTRL);
            default:
                term_v = 1'b0;
        endcase
        return term_v;
    endfunction

endpackage

// File: rtl/ipg_rr_arb.sv
// Combinational round-robin picker: returns the first requesting index at or
// after rr_ptr_i, wrapping around NUM_REQ.
module ipg_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [PTR_W-1:0]   winner_o,
    output logic               any_req_o
);

    // Scan offsets from farthest to nearest so the nearest requester overrides.
    always_comb begin
        winner_o  = '0;
        any_req_o = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int               sum_v;
            logic [PTR_W-1:0] idx_v;
            sum_v     = int'(rr_ptr_i) + i;
            idx_v     = (sum_v >= NUM_REQ) ? PTR_W'(sum_v - NUM_REQ) : PTR_W'(sum_v);
            winner_o  = req_i[idx_v] ? idx_v : winner_o;
            any_req_o = any_req_o | req_i[idx_v];
        end
    end

endmodule

// File: rtl/ipg_slot_sched.sv
// IPG slot scheduler: grants one requester at a time (round-robin) and pops
// one IPG chunk per qualifying idle block of the 64b/66b TX stream.
module ipg_slot_sched
    import ipg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 7,
    parameter int MIN_GAP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               blk_hdr,
    input  logic [63:0]              blk_data,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     chunk_rd,
    output logic                     ipg_en,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       abort,
    output logic [LEN_W-1:0]         remaining
);

    localparam int         PTR_W     = $clog2(NUM_REQ);
    localparam logic [3:0] MIN_GAP_C = 4'(MIN_GAP);
    localparam logic [NUM_REQ-1:0] ONE_C = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   abort_q, abort_d;
    logic [PTR_W-1:0]     win_q, win_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [3:0]           gap_q, gap_d;
    logic                 ipg_en_q;

    logic [PTR_W-1:0]     winner_s;
    logic                 any_req_s;
    logic                 idle_s, term_s, slot_ok_s, chunk_rd_s;
    logic [LEN_W-1:0]     len_s;
    logic [NUM_REQ-1:0]   new_oh_s, cur_oh_s;
    logic [PTR_W-1:0]     nxt_ptr_s;

    ipg_rr_arb #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (winner_s),
        .any_req_o (any_req_s)
    );

    assign idle_s    = is_idle_blk(blk_hdr, blk_data);
    assign term_s    = is_term_blk(blk_hdr, blk_data);
    // The gap test uses the count before this block updates it.
    assign slot_ok_s = idle_s && (gap_q >= MIN_GAP_C);
    assign len_s     = req_len[int'(winner_s)*LEN_W +: LEN_W];
    assign new_oh_s  = ONE_C << winner_s;
    assign cur_oh_s  = ONE_C << win_q;
    assign nxt_ptr_s = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + PTR_W'(1);

    // Post-frame gap counter: cleared by terminate, counts idles up to MIN_GAP.
    always_comb begin
        gap_d = gap_q;
        if (term_s) begin
            gap_d = 4'd0;
        end else if (idle_s && (gap_q < MIN_GAP_C)) begin
            gap_d = gap_q + 4'd1;
        end else begin
            gap_d = gap_q;
        end
    end

    // Arbitration/transfer FSM next-state and pulse generation.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        win_d      = win_q;
        rem_d      = rem_q;
        rr_ptr_d   = rr_ptr_q;
        done_d     = '0;
        abort_d    = '0;
        chunk_rd_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    win_d = winner_s;
                    rem_d = len_s;
                    if (len_s == '0) begin
                        // Empty message completes immediately without a grant.
                        done_d  = new_oh_s;
                        state_d = S_DONE;
                    end else begin
                        grant_d = new_oh_s;
                        state_d = S_XFER;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                chunk_rd_s = slot_ok_s;
                rem_d      = slot_ok_s ? rem_q - LEN_W'(1) : rem_q;
                if (slot_ok_s && (rem_q == LEN_W'(1))) begin
                    // Completion takes priority over a simultaneous request drop.
                    done_d  = cur_oh_s;
                    state_d = S_DONE;
                end else if (!req[win_q]) begin
                    abort_d = cur_oh_s;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_DONE: begin
                grant_d  = '0;
                rr_ptr_d = nxt_ptr_s;
                state_d  = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            abort_q  <= '0;
            win_q    <= '0;
            rr_ptr_q <= '0;
            rem_q    <= '0;
            gap_q    <= 4'd0;
            ipg_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            win_q    <= win_d;
            rr_ptr_q <= rr_ptr_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            ipg_en_q <= chunk_rd_s;
        end
    end

    assign grant     = grant_q;
    assign chunk_rd  = chunk_rd_s;
    assign ipg_en    = ipg_en_q;
    assign done      = done_q;
    assign abort     = abort_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_ipg_slot_sched.sv
// Scoreboard bench for ipg_slot_sched: directed block/request sequences push
// expected events (cycle-stamped) into per-kind queues; a negedge monitor
// pops and compares whenever the DUT shows grant changes, pops, ipg_en,
// done or abort.
module tb_ipg_slot_sched;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 7;

    localparam logic [1:0]  H_CTRL  = 2'b01;
    localparam logic [1:0]  H_DATA  = 2'b10;
    localparam logic [1:0]  H_BAD   = 2'b00;
    localparam logic [63:0] D_IDLE  = 64'h0000_0000_0000_001e;
    localparam logic [63:0] D_DATA  = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] D_START = 64'hd555_5555_5555_5578;
    localparam logic [63:0] D_TERM3 = 64'h0000_0000_3322_11b4;
    localparam logic [63:0] D_TERM0 = 64'h0000_0000_0000_0087;
    localparam logic [63:0] D_BADC  = 64'h0000_0000_0000_011e;
    localparam logic [63:0] D_OS    = 64'h0000_0000_0000_004b;

    localparam int K_GNT = 0, K_CHK = 1, K_IPG = 2, K_DONE = 3, K_ABT = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [1:0]               blk_hdr;
    logic [63:0]              blk_data;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       grant, done, abort;
    logic                     chunk_rd, ipg_en;
    logic [LEN_W-1:0]         remaining;

    ipg_slot_sched #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .MIN_GAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_hdr   (blk_hdr),
        .blk_data  (blk_data),
        .req       (req),
        .req_len   (req_len),
        .grant     (grant),
        .chunk_rd  (chunk_rd),
        .ipg_en    (ipg_en),
        .done      (done),
        .abort     (abort),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
        logic [7:0] rem;
    } ev_t;

    ev_t q_gnt[$], q_chk[$], q_ipg[$], q_done[$], q_abt[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    task automatic push_ev(input int kind, input int c, input logic [7:0] v, input logic [7:0] r);
        ev_t e;
        e.cyc = c; e.vec = v; e.rem = r;
        case (kind)
            K_GNT:   q_gnt.push_back(e);
            K_CHK:   q_chk.push_back(e);
            K_IPG:   q_ipg.push_back(e);
            K_DONE:  q_done.push_back(e);
            default: q_abt.push_back(e);
        endcase
    endtask

    task automatic e_gnt(input int c, input logic [7:0] v);             push_ev(K_GNT, c, v, 8'd0); endtask
    task automatic e_chk(input int c, input logic [7:0] v, input int r); push_ev(K_CHK, c, v, 8'(r)); endtask
    task automatic e_ipg(input int c);                                   push_ev(K_IPG, c, 8'd0, 8'd0); endtask
    task automatic e_done(input int c, input logic [7:0] v);             push_ev(K_DONE, c, v, 8'd0); endtask
    task automatic e_abt(input int c, input logic [7:0] v);              push_ev(K_ABT, c, v, 8'd0); endtask

    task automatic observe(input int kind, input string name, input logic [7:0] v, input logic [7:0] r);
        ev_t  e;
        logic have;
        have = 1'b0;
        case (kind)
            K_GNT:   if (q_gnt.size()  > 0) begin e = q_gnt.pop_front();  have = 1'b1; end
            K_CHK:   if (q_chk.size()  > 0) begin e = q_chk.pop_front();  have = 1'b1; end
            K_IPG:   if (q_ipg.size()  > 0) begin e = q_ipg.pop_front();  have = 1'b1; end
            K_DONE:  if (q_done.size() > 0) begin e = q_done.pop_front(); have = 1'b1; end
            default: if (q_abt.size()  > 0) begin e = q_abt.pop_front();  have = 1'b1; end
        endcase
        n_checks++;
        if (!have)
            $display("FAIL %s: unexpected event at cycle %0d vec=%h rem=%0d, required none", name, cyc, v, r);
        else if (e.cyc != cyc || e.vec !== v || e.rem !== r)
            $display("FAIL %s: got cycle %0d vec=%h rem=%0d, required cycle %0d vec=%h rem=%0d",
                     name, cyc, v, r, e.cyc, e.vec, e.rem);
        else
            n_pass++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every visible DUT event is matched against the scoreboard.
    always @(negedge clk) begin
        if (grant !== prev_grant) observe(K_GNT, "grant", 8'(grant), 8'd0);
        prev_grant <= grant;
        if (chunk_rd)      observe(K_CHK, "chunk_rd", 8'(grant), 8'(remaining));
        if (ipg_en)        observe(K_IPG, "ipg_en", 8'd0, 8'd0);
        if (done != '0)    observe(K_DONE, "done", 8'(done), 8'(remaining));
        if (abort != '0)   observe(K_ABT, "abort", 8'(abort), 8'(grant));
    end

    task automatic step(input logic [1:0] h, input logic [63:0] d);
        @(posedge clk);
        #1;
        blk_hdr  = h;
        blk_data = d;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},     int'(grant),     0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_abort"},     int'(abort),     0);
        chk({tag, "_ipg_en"},    int'(ipg_en),    0);
        chk({tag, "_chunk_rd"},  int'(chunk_rd),  0);
        chk({tag, "_remaining"}, int'(remaining), 0);
    endtask

    initial begin
        #100000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        int t;
        rst = 1'b1; blk_hdr = H_DATA; blk_data = D_DATA; req = '0; req_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // T1: first idle after reset only satisfies the gap; next two carry chunks.
        step(H_DATA, D_DATA); req = 4'b0001; set_len(0, 2); t = cyc;
        e_gnt(t+1, 8'h01);
        e_chk(t+2, 8'h01, 2); e_ipg(t+3);
        e_chk(t+3, 8'h01, 1); e_ipg(t+4); e_done(t+4, 8'h01);
        e_gnt(t+5, 8'h00);
        repeat (3) step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE); req = 4'b0000;
        step(H_CTRL, D_IDLE);

        // T2: two requesters, round-robin order 1 then 3 with a grant gap.
        step(H_CTRL, D_IDLE); req = 4'b1010; set_len(1, 1); set_len(3, 1); t = cyc;
        e_gnt(t+1, 8'h02); e_chk(t+1, 8'h02, 1); e_ipg(t+2); e_done(t+2, 8'h02);
        e_gnt(t+3, 8'h00);
        e_gnt(t+4, 8'h08); e_chk(t+4, 8'h08, 1); e_ipg(t+5); e_done(t+5, 8'h08);
        e_gnt(t+6, 8'h00);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE); req = 4'b1000;
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE); req = 4'b0000;
        step(H_CTRL, D_IDLE);

        // T3: pointer wrapped to 0; a frame stalls the message mid-way.
        step(H_CTRL, D_IDLE); req = 4'b0101; set_len(0, 4); set_len(2, 5); t = cyc;
        e_gnt(t+1, 8'h01);
        e_chk(t+1, 8'h01, 4); e_ipg(t+2);
        e_chk(t+2, 8'h01, 3); e_ipg(t+3);
        e_chk(t+11, 8'h01, 2); e_ipg(t+12);
        e_chk(t+12, 8'h01, 1); e_ipg(t+13); e_done(t+13, 8'h01);
        e_gnt(t+14, 8'h00);
        e_gnt(t+15, 8'h04);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_START);
        repeat (5) step(H_DATA, D_DATA);
        step(H_CTRL, D_TERM3);
        repeat (3) step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE); req = 4'b0100;
        step(H_CTRL, D_IDLE);

        // T4: non-idle control blocks neither pop nor advance the gap; then abort.
        step(H_CTRL, D_BADC); t = cyc;
        e_chk(t+3, 8'h04, 5); e_ipg(t+4);
        e_chk(t+7, 8'h04, 4); e_ipg(t+8);
        e_abt(t+9, 8'h04); e_gnt(t+9, 8'h00);
        step(H_CTRL, D_OS);
        step(H_BAD,  D_IDLE);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_TERM0);
        step(H_CTRL, D_BADC);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE);
        step(H_DATA, D_DATA); req = 4'b0000;
        step(H_CTRL, D_IDLE);

        // T5: request drop in the same cycle as the final chunk completes normally.
        step(H_CTRL, D_IDLE); req = 4'b0010; set_len(1, 1); t = cyc;
        e_gnt(t+1, 8'h02); e_chk(t+1, 8'h02, 1); e_ipg(t+2); e_done(t+2, 8'h02);
        e_gnt(t+3, 8'h00);
        step(H_CTRL, D_IDLE); req = 4'b0000;
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE);

        // T6: zero-length request completes with no grant and no pop.
        step(H_CTRL, D_IDLE); req = 4'b0100; set_len(2, 0); t = cyc;
        e_done(t+1, 8'h04);
        step(H_CTRL, D_IDLE); req = 4'b0000;
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE);

        // T7: reset mid-transfer clears everything without done/abort.
        step(H_DATA, D_DATA); req = 4'b0001; set_len(0, 4); t = cyc;
        e_gnt(t+1, 8'h01);
        e_chk(t+1, 8'h01, 4); e_ipg(t+2);
        e_chk(t+2, 8'h01, 3);
        e_gnt(t+3, 8'h00);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE);
        step(H_CTRL, D_IDLE); rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        step(H_CTRL, D_IDLE); rst = 1'b0; req = 4'b0000;
        repeat (4) step(H_CTRL, D_IDLE);
        @(negedge clk);
        @(posedge clk); #1;

        chk("pending_grant",    q_gnt.size(),  0);
        chk("pending_chunk_rd", q_chk.size(),  0);
        chk("pending_ipg_en",   q_ipg.size(),  0);
        chk("pending_done",     q_done.size(), 0);
        chk("pending_abort",    q_abt.size(),  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
